rename_ckpt_stage: RTL and testbench

- Parametrised register-rename stage between decode and issue.
- Maps architectural to physical registers through a speculative map table and a circular free list.
- Takes a snapshot (checkpoint) at every branch, so a mispredict restores state in one cycle from that branch's snapshot, instead of draining to commit.
- Commit returns freed physical registers to the free list.

---
 rtl/rename_ckpt_stage.sv | 120 ++++++++++++
 tb/tb_rename_ckpt_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ckpt_stage.sv
// rename_ckpt_stage: map-table rename with circular free list and per-branch checkpoints.
// Optional macro RENAME_ZERO_REG_EN hardwires architectural r0 to physical 0.
module rename_ckpt_stage #(
  parameter int NUM_ARCH_REG = 16,
  parameter int NUM_PHYS_REG = 64,
  parameter int NUM_CKPT     = 4,
  localparam int AW = $clog2(NUM_ARCH_REG),
  localparam int PW = $clog2(NUM_PHYS_REG),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          dec_v_i,
  output logic          dec_ready_o,
  input  logic [AW-1:0] dec_src1_i,
  input  logic [AW-1:0] dec_src2_i,
  input  logic [AW-1:0] dec_dest_i,
  input  logic          dec_w_v_i,
  input  logic          dec_branch_i,
  output logic          ren_v_o,
  input  logic          ren_ready_i,
  output logic [PW-1:0] ren_src1_o,
  output logic [PW-1:0] ren_src2_o,
  output logic [PW-1:0] ren_dest_o,
  output logic [PW-1:0] ren_freed_o,
  output logic [CW-1:0] ren_ckpt_o,
  input  logic          commit_v_i,
  input  logic          commit_w_v_i,
  input  logic [PW-1:0] commit_freed_i,
  input  logic          resolve_v_i,
  input  logic [CW-1:0] resolve_ckpt_i,
  input  logic          resolve_mispredict_i
);
  localparam int FREE = NUM_PHYS_REG - NUM_ARCH_REG;
  logic [PW-1:0] map_q [NUM_ARCH_REG];
  logic [PW-1:0] map_nxt [NUM_ARCH_REG];
  logic [PW-1:0] fl_q [NUM_PHYS_REG];
  logic [PW-1:0] ck_map_q [NUM_CKPT][NUM_ARCH_REG];
  logic [PW-1:0] ck_rd_q [NUM_CKPT];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt, src1_map, src2_map;
  logic [PW:0]   fl_cnt;
  logic [CW-1:0] head, tail;
  logic [CW:0]   ck_cnt;
  logic advance, recover, alloc_w, accept, alloc, ck_alloc, push, res_ok;
  assign advance = !ren_v_o || ren_ready_i;
  assign recover = resolve_v_i && resolve_mispredict_i;
  assign res_ok  = resolve_v_i && !resolve_mispredict_i;
`ifdef RENAME_ZERO_REG_EN
  assign alloc_w  = dec_w_v_i && dec_dest_i != '0;
  assign src1_map = dec_src1_i == '0 ? '0 : map_q[dec_src1_i];
  assign src2_map = dec_src2_i == '0 ? '0 : map_q[dec_src2_i];
`else
  assign alloc_w  = dec_w_v_i;
  assign src1_map = map_q[dec_src1_i];
  assign src2_map = map_q[dec_src2_i];
`endif
  assign dec_ready_o = advance && !recover && (!alloc_w || fl_cnt != '0) &&
                       (!dec_branch_i || ck_cnt != (CW+1)'(NUM_CKPT));
  assign accept     = dec_v_i && dec_ready_o;
  assign alloc      = accept && alloc_w;
  assign ck_alloc   = accept && dec_branch_i;
  assign push       = commit_v_i && commit_w_v_i;
  assign rd_ptr_nxt = rd_ptr + PW'(alloc);
  assign wr_ptr_nxt = wr_ptr + PW'(push);
  always_comb begin
    map_nxt = map_q;
    if (alloc) map_nxt[dec_dest_i] = fl_q[rd_ptr];
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < NUM_PHYS_REG; i++) fl_q[i] <= PW'(NUM_ARCH_REG + i);
      rd_ptr      <= '0;
      wr_ptr      <= PW'(FREE);
      fl_cnt      <= (PW+1)'(FREE);
      head        <= '0;
      tail        <= '0;
      ck_cnt      <= '0;
      ren_v_o     <= 1'b0;
      ren_src1_o  <= '0;
      ren_src2_o  <= '0;
      ren_dest_o  <= '0;
      ren_freed_o <= '0;
      ren_ckpt_o  <= '0;
    end else begin
      if (push) fl_q[wr_ptr] <= commit_freed_i;
      wr_ptr <= wr_ptr_nxt;
      head   <= head + CW'(res_ok);
      if (recover) begin
        map_q   <= ck_map_q[resolve_ckpt_i];
        rd_ptr  <= ck_rd_q[resolve_ckpt_i];
        tail    <= resolve_ckpt_i;
        ck_cnt  <= {1'b0, resolve_ckpt_i - head};
        fl_cnt  <= {1'b0, wr_ptr_nxt - ck_rd_q[resolve_ckpt_i]};
        ren_v_o <= 1'b0;
      end else begin
        map_q  <= map_nxt;
        rd_ptr <= rd_ptr_nxt;
        tail   <= tail + CW'(ck_alloc);
        ck_cnt <= ck_cnt + (CW+1)'(ck_alloc) - (CW+1)'(res_ok);
        fl_cnt <= fl_cnt + (PW+1)'(push) - (PW+1)'(alloc);
        if (advance) ren_v_o <= accept;
        if (accept) begin
          ren_src1_o  <= src1_map;
          ren_src2_o  <= src2_map;
          ren_dest_o  <= alloc ? fl_q[rd_ptr] : '0;
          ren_freed_o <= alloc ? map_q[dec_dest_i] : '0;
          ren_ckpt_o  <= tail;
        end
      end
    end
  end
  // snapshot holds the map as it stands after this branch's own allocation
  always_ff @(posedge clk_i) begin
    if (ck_alloc) begin
      ck_map_q[tail] <= map_nxt;
      ck_rd_q[tail]  <= rd_ptr_nxt;
    end
  end
endmodule

// File: tb/tb_rename_ckpt_stage.sv
// tb_rename_ckpt_stage: scoreboard bench for rename_ckpt_stage at default parameters.
module tb_rename_ckpt_stage;
`ifdef RENAME_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 1'b0, reset_n_i;
  logic dec_v_i, dec_ready_o, dec_w_v_i, dec_branch_i;
  logic [3:0] dec_src1_i, dec_src2_i, dec_dest_i;
  logic ren_v_o, ren_ready_i;
  logic [5:0] ren_src1_o, ren_src2_o, ren_dest_o, ren_freed_o, commit_freed_i;
  logic [1:0] ren_ckpt_o, resolve_ckpt_i;
  logic commit_v_i, commit_w_v_i, resolve_v_i, resolve_mispredict_i;
  typedef struct {int s1; int s2; int d; int f; int c; bit br;} exp_t;
  exp_t q[$];
  int m_map[16], m_fl[64], ck_m[4][16], ck_r[4];
  int m_rd, m_wr, m_cnt, m_head, m_tail, m_ckc;
  int checks = 0, errors = 0;
  bit live = 1'b0;
  rename_ckpt_stage dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .dec_v_i(dec_v_i), .dec_ready_o(dec_ready_o),
    .dec_src1_i(dec_src1_i), .dec_src2_i(dec_src2_i), .dec_dest_i(dec_dest_i),
    .dec_w_v_i(dec_w_v_i), .dec_branch_i(dec_branch_i), .ren_v_o(ren_v_o),
    .ren_ready_i(ren_ready_i), .ren_src1_o(ren_src1_o), .ren_src2_o(ren_src2_o),
    .ren_dest_o(ren_dest_o), .ren_freed_o(ren_freed_o), .ren_ckpt_o(ren_ckpt_o),
    .commit_v_i(commit_v_i), .commit_w_v_i(commit_w_v_i), .commit_freed_i(commit_freed_i),
    .resolve_v_i(resolve_v_i), .resolve_ckpt_i(resolve_ckpt_i),
    .resolve_mispredict_i(resolve_mispredict_i)
  );
  always #5 clk = ~clk;
  function automatic bit w_alloc();
    return dec_w_v_i && !(ZR && dec_dest_i == 4'd0);
  endfunction
  function automatic bit exp_ready();
    return (q.size() == 0 || ren_ready_i) && !(resolve_v_i && resolve_mispredict_i) &&
           (!w_alloc() || m_cnt != 0) && (!dec_branch_i || m_ckc != 4);
  endfunction
  task automatic idle();
    dec_v_i = 0; dec_w_v_i = 0; dec_branch_i = 0; dec_src1_i = 0; dec_src2_i = 0;
    dec_dest_i = 0; ren_ready_i = 1; commit_v_i = 0; commit_w_v_i = 0; commit_freed_i = 0;
    resolve_v_i = 0; resolve_mispredict_i = 0; resolve_ckpt_i = 0;
  endtask
  task automatic dec(input int s1, input int s2, input int d, input bit w, input bit br);
    dec_v_i = 1; dec_src1_i = 4'(s1); dec_src2_i = 4'(s2); dec_dest_i = 4'(d);
    dec_w_v_i = w; dec_branch_i = br;
  endtask
  // one clock: decide acceptance before the edge, advance the model after it
  task automatic cyc();
    exp_t e;
    bit acc, trans;
    int k;
    #1;
    acc = dec_v_i && exp_ready();
    trans = q.size() != 0 && ren_ready_i;
    @(posedge clk);
    if (trans) void'(q.pop_front());
    if (acc) begin
      e.s1 = (ZR && dec_src1_i == 0) ? 0 : m_map[dec_src1_i];
      e.s2 = (ZR && dec_src2_i == 0) ? 0 : m_map[dec_src2_i];
      e.d = 0; e.f = 0; e.c = 0; e.br = dec_branch_i;
      if (w_alloc()) begin
        e.d = m_fl[m_rd]; e.f = m_map[dec_dest_i]; m_map[dec_dest_i] = e.d;
        m_rd = (m_rd + 1) % 64; m_cnt--;
      end
      if (dec_branch_i) begin
        ck_m[m_tail] = m_map; ck_r[m_tail] = m_rd; e.c = m_tail;
        m_tail = (m_tail + 1) % 4; m_ckc++;
      end
      q.push_back(e);
    end
    if (commit_v_i && commit_w_v_i) begin
      m_fl[m_wr] = commit_freed_i; m_wr = (m_wr + 1) % 64; m_cnt++;
    end
    if (resolve_v_i && resolve_mispredict_i) begin
      k = resolve_ckpt_i;
      m_map = ck_m[k]; m_rd = ck_r[k]; m_tail = k; m_ckc = (k - m_head) & 3;
      m_cnt = (m_wr - m_rd) & 63; q.delete();
    end else if (resolve_v_i) begin
      m_head = (m_head + 1) % 4; m_ckc--;
    end
    #1;
  endtask
  task automatic do_reset();
    idle();
    reset_n_i = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_n_i = 1;
    for (int i = 0; i < 16; i++) m_map[i] = i;
    for (int i = 0; i < 64; i++) m_fl[i] = (16 + i) % 64;
    m_rd = 0; m_wr = 48; m_cnt = 48; m_head = 0; m_tail = 0; m_ckc = 0;
    q.delete();
  endtask
  always @(negedge clk) if (live && reset_n_i) begin
    checks++;
    if (ren_v_o !== (q.size() != 0)) begin
      errors++; $display("FAIL ren_v: got %0b want %0b", ren_v_o, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if (ren_src1_o !== 6'(q[0].s1) || ren_src2_o !== 6'(q[0].s2) ||
          ren_dest_o !== 6'(q[0].d) || ren_freed_o !== 6'(q[0].f) ||
          (q[0].br && ren_ckpt_o !== 2'(q[0].c))) begin
        errors++;
        $display("FAIL ren_data: got s1=%0d s2=%0d d=%0d f=%0d c=%0d want s1=%0d s2=%0d d=%0d f=%0d c=%0d",
                 ren_src1_o, ren_src2_o, ren_dest_o, ren_freed_o, ren_ckpt_o,
                 q[0].s1, q[0].s2, q[0].d, q[0].f, q[0].c);
      end
    end
    checks++;
    if (dec_ready_o !== exp_ready()) begin
      errors++; $display("FAIL dec_ready: got %0b want %0b", dec_ready_o, exp_ready());
    end
    checks++;
    if (dut.fl_cnt !== 7'(m_cnt) || dut.ck_cnt !== 3'(m_ckc)) begin
      errors++;
      $display("FAIL counts: got fl=%0d ck=%0d want fl=%0d ck=%0d", dut.fl_cnt, dut.ck_cnt, m_cnt, m_ckc);
    end
  end
  task automatic test_reset();
    dec(1, 2, 3, 1, 0); cyc(); cyc();
    do_reset();
    checks++;
    if (ren_v_o !== 0 || ren_dest_o !== 0 || ren_freed_o !== 0 || ren_src1_o !== 0 ||
        dut.fl_cnt !== 7'd48 || dut.ck_cnt !== 3'd0 || dut.rd_ptr !== 6'd0 || dut.wr_ptr !== 6'd48) begin
      errors++;
      $display("FAIL reset: got v=%0b d=%0d fl=%0d ck=%0d rd=%0d wr=%0d want 0 0 48 0 0 48",
               ren_v_o, ren_dest_o, dut.fl_cnt, dut.ck_cnt, dut.rd_ptr, dut.wr_ptr);
    end
  endtask
  task automatic test_basic();
    do_reset();
    dec(1, 2, 3, 1, 0); cyc(); idle();
    checks++;
    if (ren_v_o !== 1 || ren_src1_o !== 6'd1 || ren_src2_o !== 6'd2 || ren_dest_o !== 6'd16 ||
        ren_freed_o !== 6'd3 || dut.fl_cnt !== 7'd47) begin
      errors++;
      $display("FAIL basic: got s1=%0d s2=%0d d=%0d f=%0d fl=%0d want 1 2 16 3 47",
               ren_src1_o, ren_src2_o, ren_dest_o, ren_freed_o, dut.fl_cnt);
    end
    dec(3, 3, 3, 1, 0); cyc(); idle();
    checks++;
    if (ren_src1_o !== 6'd16 || ren_freed_o !== 6'd16 || ren_dest_o !== 6'd17) begin
      errors++;
      $display("FAIL src_eq_dest: got s1=%0d f=%0d d=%0d want 16 16 17", ren_src1_o, ren_freed_o, ren_dest_o);
    end
    cyc();
  endtask
  task automatic test_free_full();
    do_reset();
    for (int i = 0; i < 48; i++) begin dec(i % 16, (i + 5) % 16, (i + 1) % 16, 1, 0); cyc(); end
    dec(2, 3, 4, 1, 0); #1;
    checks++;
    if (dec_ready_o !== 0) begin errors++; $display("FAIL fl_empty_stall: got %0b want 0", dec_ready_o); end
    cyc();
    dec(2, 3, 4, 0, 0); cyc();
    idle(); commit_v_i = 1; commit_w_v_i = 1; commit_freed_i = 6'd5; cyc();
    idle(); dec(7, 8, 9, 1, 0); cyc(); idle();
    checks++;
    if (ren_v_o !== 1 || ren_dest_o !== 6'd5) begin
      errors++; $display("FAIL fl_wrap: got v=%0b d=%0d want 1 5", ren_v_o, ren_dest_o);
    end
    cyc();
  endtask
  task automatic test_mispredict();
    do_reset();
    dec(1, 2, 3, 1, 0); cyc();
    dec(0, 0, 0, 0, 1); cyc();
    dec(4, 4, 4, 1, 0); cyc(); idle();
    checks++;
    if (ren_dest_o !== 6'd17) begin errors++; $display("FAIL pre_misp_dest: got %0d want 17", ren_dest_o); end
    resolve_v_i = 1; resolve_mispredict_i = 1; resolve_ckpt_i = 0; cyc(); idle();
    checks++;
    if (dut.map_q[4] !== 6'd4 || dut.rd_ptr !== 6'd1 || dut.fl_cnt !== 7'd47 || ren_v_o !== 0) begin
      errors++;
      $display("FAIL misp_restore: got map4=%0d rd=%0d fl=%0d v=%0b want 4 1 47 0",
               dut.map_q[4], dut.rd_ptr, dut.fl_cnt, ren_v_o);
    end
    dec(4, 1, 4, 1, 0); cyc(); idle();
    checks++;
    if (ren_dest_o !== 6'd17 || ren_freed_o !== 6'd4) begin
      errors++; $display("FAIL misp_realloc: got d=%0d f=%0d want 17 4", ren_dest_o, ren_freed_o);
    end
    cyc();
  endtask
  task automatic test_ckpt_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin dec(i, i, 0, 0, 1); cyc(); end
    dec(5, 6, 0, 0, 1); #1;
    checks++;
    if (dec_ready_o !== 0) begin errors++; $display("FAIL ck_full_stall: got %0b want 0", dec_ready_o); end
    cyc();
    resolve_v_i = 1; resolve_ckpt_i = 0; cyc();
    resolve_v_i = 0; cyc(); idle();
    checks++;
    if (ren_v_o !== 1 || ren_ckpt_o !== 2'd0 || dut.ck_cnt !== 3'd4) begin
      errors++; $display("FAIL ck_reuse: got v=%0b c=%0d ck=%0d want 1 0 4", ren_v_o, ren_ckpt_o, dut.ck_cnt);
    end
    cyc();
  endtask
  task automatic test_misp_commit();
    do_reset();
    dec(1, 1, 0, 0, 1); cyc();
    dec(1, 2, 5, 1, 0); cyc();
    dec(1, 1, 0, 0, 1); cyc();
    dec(2, 3, 6, 1, 0); cyc();
    dec(1, 1, 0, 0, 1); cyc();
    dec(1, 1, 0, 0, 1); cyc(); idle();
    resolve_v_i = 1; resolve_mispredict_i = 1; resolve_ckpt_i = 1;
    commit_v_i = 1; commit_w_v_i = 1; commit_freed_i = 6'd9; cyc(); idle();
    checks++;
    if (dut.tail !== 2'd1 || dut.ck_cnt !== 3'd1 || dut.fl_cnt !== 7'd48 || dut.fl_q[48] !== 6'd9) begin
      errors++;
      $display("FAIL misp_commit: got tail=%0d ck=%0d fl=%0d fl48=%0d want 1 1 48 9",
               dut.tail, dut.ck_cnt, dut.fl_cnt, dut.fl_q[48]);
    end
    cyc();
  endtask
  task automatic test_back_to_back();
    logic [5:0] hold_d;
    do_reset();
    dec(1, 2, 7, 1, 0); cyc();
    hold_d = ren_dest_o;
    dec(3, 4, 8, 1, 0); ren_ready_i = 0;
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (ren_dest_o !== hold_d || ren_v_o !== 1 || dut.fl_cnt !== 7'd47) begin
      errors++; $display("FAIL hold: got d=%0d v=%0b fl=%0d want %0d 1 47", ren_dest_o, ren_v_o, dut.fl_cnt, hold_d);
    end
    ren_ready_i = 1; cyc(); idle(); cyc();
`ifdef RENAME_ZERO_REG_EN
    dec(0, 5, 0, 1, 0); cyc(); idle();
    checks++;
    if (ren_dest_o !== 0 || ren_freed_o !== 0 || ren_src1_o !== 0 || dut.fl_cnt !== 7'd46) begin
      errors++;
      $display("FAIL zero_reg: got d=%0d f=%0d s1=%0d fl=%0d want 0 0 0 46", ren_dest_o, ren_freed_o, ren_src1_o, dut.fl_cnt);
    end
    cyc();
`endif
  endtask
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom % 4 != 0) dec($urandom % 16, $urandom % 16, $urandom % 16, $urandom % 4 != 0, $urandom % 5 == 0);
      ren_ready_i = $urandom % 4 != 0;
      if (m_cnt < 40 && $urandom % 3 == 0) begin
        commit_v_i = 1; commit_w_v_i = $urandom % 5 != 0; commit_freed_i = 6'($urandom);
      end
      if (m_ckc > 0 && $urandom % 4 == 0) begin
        resolve_v_i = 1; resolve_mispredict_i = $urandom % 3 == 0;
        resolve_ckpt_i = resolve_mispredict_i ? 2'((m_head + $urandom_range(0, m_ckc - 1)) % 4) : 2'(m_head);
      end
      cyc();
    end
    idle(); cyc();
  endtask
  initial begin
    idle();
    reset_n_i = 0;
    do_reset();
    live = 1'b1;
    test_reset();
    test_basic();
    test_free_full();
    test_mispredict();
    test_ckpt_full();
    test_misp_commit();
    test_back_to_back();
    test_random();
    @(posedge clk); #1;
    live = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
